// File: rtl/keyscan.sv
// 4x4 active-low keypad scanner: column drive, 2-FF row synchronizer, frame assembly
// and frame-count debounce. Define KEYSCAN_GHOST_REJECT_EN to discard frames with >2 keys.
module keyscan #(
    parameter logic [15:0] SCAN_DIV   = 16'd1000,
    parameter int unsigned DEBOUNCE_N = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] keys,
    output logic        key_chg
);

    localparam logic [15:0] DIV_LAST = SCAN_DIV - 16'd1;
    localparam logic [3:0]  CNT_MAX  = 4'(DEBOUNCE_N - 1);

    logic [3:0]  sync1_q, sync2_q;
    logic [15:0] div_q, div_d;
    logic [1:0]  c_q, c_d;
    logic [3:0]  col_q, col_d;
    logic [11:0] frame_q, frame_d;
    logic [15:0] prev_q, prev_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] keys_q, keys_d;
    logic        key_chg_q, key_chg_d;

    logic [15:0] cur;
    logic        sample, frame_end, same, stable, unstable;
    logic [4:0]  cnt_inc;

    // Column 3 is never stored: it is folded straight into the frame being judged.
    assign cur       = {~sync2_q, frame_q};
    assign sample    = (div_q == DIV_LAST);
    assign frame_end = sample && (c_q == 2'd3);
    assign same      = (cur == prev_q);
    assign cnt_inc   = {1'b0, cnt_q} + 5'd1;
    assign stable    = same && (cnt_inc >= {1'b0, CNT_MAX});

`ifdef KEYSCAN_GHOST_REJECT_EN
    logic [4:0] pop;
    always_comb begin
        pop = 5'd0;
        for (int i = 0; i < 16; i++) begin
            pop = pop + 5'(cur[i]);
        end
    end
    assign unstable = (pop > 5'd2);
`else
    assign unstable = 1'b0;
`endif

    always_comb begin
        div_d     = div_q + 16'd1;
        c_d       = c_q;
        frame_d   = frame_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        keys_d    = keys_q;
        key_chg_d = 1'b0;

        if (sample) begin
            div_d = 16'd0;
            c_d   = c_q + 2'd1;
            case (c_q)
                2'd0:    frame_d[3:0]  = ~sync2_q;
                2'd1:    frame_d[7:4]  = ~sync2_q;
                2'd2:    frame_d[11:8] = ~sync2_q;
                default: frame_d       = frame_q;
            endcase
        end

        if (frame_end) begin
            prev_d = cur;
            if (!same || unstable) begin
                cnt_d = 4'd0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 4'd1;
            end
            if (stable && !unstable && (cur != keys_q)) begin
                keys_d    = cur;
                key_chg_d = 1'b1;
            end
        end

        col_d = ~(4'b0001 << c_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 4'b1111;
            sync2_q   <= 4'b1111;
            div_q     <= 16'd0;
            c_q       <= 2'd0;
            col_q     <= 4'b1110;
            frame_q   <= 12'd0;
            prev_q    <= 16'd0;
            cnt_q     <= 4'd0;
            keys_q    <= 16'd0;
            key_chg_q <= 1'b0;
        end else begin
            sync1_q   <= row_in;
            sync2_q   <= sync1_q;
            div_q     <= div_d;
            c_q       <= c_d;
            col_q     <= col_d;
            frame_q   <= frame_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            keys_q    <= keys_d;
            key_chg_q <= key_chg_d;
        end
    end

    assign col_out = col_q;
    assign keys    = keys_q;
    assign key_chg = key_chg_q;

endmodule

// File: tb/tb_keyscan.sv
// Directed bench for keyscan (SCAN_DIV=4, DEBOUNCE_N=3, 16-cycle frames) with a
// behavioural keypad matrix driving the rows from the pressed-key mask.
module tb_keyscan;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] keys;
    logic        key_chg;

    logic [15:0] pressed;
    int          errors = 0;
    int          checks = 0;
    int          chg_cnt = 0;

    typedef struct {
        logic [15:0] press;
        int          frames;
        logic [15:0] exp_keys;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[11];

    keyscan #(
        .SCAN_DIV  (16'd4),
        .DEBOUNCE_N(3)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .row_in (row_in),
        .col_out(col_out),
        .keys   (keys),
        .key_chg(key_chg)
    );

    always #5 clock = ~clock;

    // Keypad model: a pressed key shorts its row to its column when that column is low.
    always_comb begin
        row_in = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_out[c] && pressed[c*4+r]) row_in[r] = 1'b0;
            end
        end
    end

    always @(posedge key_chg) chg_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0]  exp_col;
        logic [15:0] ghost_keys;
        int          ghost_pulses;

`ifdef KEYSCAN_GHOST_REJECT_EN
        ghost_keys   = 16'h0021;
        ghost_pulses = 0;
`else
        ghost_keys   = 16'h8021;
        ghost_pulses = 1;
`endif
        vecs[0]  = '{16'h0040, 10, 16'h0040, 0};
        vecs[1]  = '{16'h0000,  2, 16'h0040, 0};
        vecs[2]  = '{16'h0000,  1, 16'h0000, 1};
        vecs[3]  = '{16'h0040,  1, 16'h0000, 0};
        vecs[4]  = '{16'h0000,  2, 16'h0000, 0};
        vecs[5]  = '{16'h0040,  2, 16'h0000, 0};
        vecs[6]  = '{16'h0040,  1, 16'h0040, 1};
        vecs[7]  = '{16'h0000,  3, 16'h0000, 1};
        vecs[8]  = '{16'h0021,  3, 16'h0021, 1};
        vecs[9]  = '{16'h8021,  3, ghost_keys, ghost_pulses};
        vecs[10] = '{16'h8021,  4, ghost_keys, 0};

        reset_n = 1'b0;
        pressed = 16'h0000;
        edges(3);
        check("rst col_out", 32'(col_out), 32'h0000000e);
        check("rst keys", 32'(keys), 32'h0);
        check("rst key_chg", 32'(key_chg), 32'h0);

        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("col step 0", 32'(col_out), 32'h0000000e);
        for (int k = 1; k <= 4; k++) begin
            edges(4);
            exp_col = ~(4'b0001 << (k % 4));
            check($sformatf("col step %0d", k), 32'(col_out), 32'(exp_col));
        end

        // Press key 6 at a frame boundary; accept lands exactly 48 edges later.
        pressed = 16'h0040;
        edges(47);
        check("press keys pre", 32'(keys), 32'h0);
        check("press chg pre", 32'(key_chg), 32'h0);
        edges(1);
        check("press keys", 32'(keys), 32'h00000040);
        check("press chg pulse", 32'(key_chg), 32'h1);
        edges(1);
        check("press chg width", 32'(key_chg), 32'h0);
        edges(15);

        for (int i = 0; i < 11; i++) begin
            pressed = vecs[i].press;
            chg_cnt = 0;
            edges(vecs[i].frames * 16);
            check($sformatf("vec%0d keys", i), 32'(keys), 32'(vecs[i].exp_keys));
            check($sformatf("vec%0d pulses", i), 32'(chg_cnt), 32'(vecs[i].exp_pulses));
        end

        // Reset during column 2 of the second frame of a press.
        pressed = 16'h0040;
        edges(16 + 9);
        reset_n = 1'b0;
        #1;
        check("midrst col_out", 32'(col_out), 32'h0000000e);
        check("midrst keys", 32'(keys), 32'h0);
        check("midrst key_chg", 32'(key_chg), 32'h0);
        edges(2);
        @(negedge clock);
        reset_n = 1'b1;
        chg_cnt = 0;
        edges(47);
        check("post rst keys pre", 32'(keys), 32'h0);
        edges(1);
        check("post rst keys", 32'(keys), 32'h00000040);
        check("post rst chg", 32'(key_chg), 32'h1);
        check("post rst pulses", 32'(chg_cnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
